// File: rtl/secuenciador_pkg.sv
// secuenciador_pkg: shared state codes, stage limits and credit width for the stage sequencer.
package secuenciador_pkg;
    typedef enum logic [1:0] {
        REPOSO  = 2'b00,
        JUGANDO = 2'b01,
        FIN     = 2'b10
    } fase_t;
    localparam logic [2:0] ETAPA_INICIAL = 3'd0;
    localparam logic [2:0] ULTIMA_ETAPA = 3'd5;
    localparam int CREDITO_W = 4;
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: rising-edge detector; the history bit resets high so a level held through reset is not an edge.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic senal,
    output logic flanco
);
    logic prev;
    always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b1;
        else prev <= senal;
    end
    assign flanco = senal & ~prev;
endmodule

// File: rtl/secuenciador_estado.sv
// secuenciador_estado: credit counter and game FSM stepping the stage index 0..5 for ControlEstado.
module secuenciador_estado
    import secuenciador_pkg::*;
#(
    parameter int MAX_CREDITOS = 15,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 moneda,
    input  logic                 boton_avance,
    input  logic                 cancelar,
    output logic [2:0]           estado,
    output logic                 avance,
    output logic                 credito,
    output logic [CREDITO_W-1:0] creditos,
    output logic                 fin,
    output logic                 timeout
);
    localparam int CW = $clog2(TIMEOUT_CICLOS);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [CREDITO_W-1:0] CRED_MAX = CREDITO_W'(MAX_CREDITOS);
    fase_t fase;
    logic [CW-1:0] cnt;
    logic fl_moneda, fl_boton, inicio;
    logic [CREDITO_W-1:0] creditos_n;
    detector_flanco u_moneda (.clk(clk), .rst_n(rst_n), .senal(moneda), .flanco(fl_moneda));
    detector_flanco u_boton (.clk(clk), .rst_n(rst_n), .senal(boton_avance), .flanco(fl_boton));
    assign inicio = (fase == REPOSO) && fl_boton && (creditos != '0);
    // A coin and a game start in the same cycle cancel out, even at saturation.
    always_comb begin
        creditos_n = (fl_moneda && !inicio) ? ((creditos == CRED_MAX) ? creditos : creditos + 1'b1) :
                     (inicio && !fl_moneda) ? creditos - 1'b1 : creditos;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fase     <= REPOSO;
            estado   <= ETAPA_INICIAL;
            avance   <= 1'b0;
            credito  <= 1'b0;
            creditos <= '0;
            fin      <= 1'b0;
            timeout  <= 1'b0;
            cnt      <= '0;
        end else begin
            creditos <= creditos_n;
            fin      <= 1'b0;
            timeout  <= 1'b0;
            case (fase)
                REPOSO: begin
                    cnt <= '0;
                    if (inicio) begin
                        fase    <= JUGANDO;
                        estado  <= ETAPA_INICIAL;
                        avance  <= 1'b1;
                        credito <= 1'b1;
                    end
                end
                JUGANDO: begin
                    if (cancelar) begin
                        fase    <= REPOSO;
                        estado  <= ETAPA_INICIAL;
                        avance  <= 1'b0;
                        credito <= 1'b0;
                        cnt     <= '0;
                    end else if (fl_boton) begin
                        cnt <= '0;
                        if (estado == ULTIMA_ETAPA) begin
                            fase   <= FIN;
                            avance <= 1'b0;
                            fin    <= 1'b1;
                        end else begin
                            estado <= estado + 3'd1;
                        end
                    end else if (cnt == CNT_MAX) begin
                        fase    <= REPOSO;
                        estado  <= ETAPA_INICIAL;
                        avance  <= 1'b0;
                        credito <= 1'b0;
                        timeout <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    fase    <= REPOSO;
                    estado  <= ETAPA_INICIAL;
                    avance  <= 1'b0;
                    credito <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/secuenciador_estado.md
# secuenciador_estado

Sequencer for the stage decoder `ControlEstado`: it holds the credit count, starts a game when a credit is available, and steps the 3-bit stage index 0..5 on each advance request. It ends the game on completion, cancel or inactivity timeout. It drives `estado`, `avance` and `credito` directly into `ControlEstado`, so `estado_actual` reads 1..6 during play and 0 otherwise. It sits between the synchronized user inputs (coin, button, cancel) and the decoder.

## Interface
- `MAX_CREDITOS`, default 15: saturation value of the credit counter; `creditos` width is 4, so MAX_CREDITOS ≤ 15.
- `TIMEOUT_CICLOS`, default 1000: idle cycles allowed in play before abort; ≥ 2.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `moneda` in 1: coin level, already synchronized; each rising edge adds one credit.
- `boton_avance` in 1: advance level, already synchronized; rising edge is a start or advance request.
- `cancelar` in 1: level; high aborts the current game.
- `estado` out 3: stage index to `ControlEstado`.
- `avance` out 1: high while playing.
- `credito` out 1: high while a consumed credit backs the current game.
- `creditos` out 4: current credit count.
- `fin` out 1: one-cycle pulse on game completion.
- `timeout` out 1: one-cycle pulse on inactivity abort.

## Operation
- Edge detect: `flanco = in & ~prev`, with `prev` registered.
  - `prev` resets to 1, so a level held high through reset produces no edge.
- FSM states: REPOSO, JUGANDO, FIN.
- REPOSO:
  - Outputs: `estado`=0, `avance`=0, `credito`=0.
  - Button edge with `creditos`>0: `creditos` −1, `estado`←0, go to JUGANDO, timeout counter cleared.
  - Button edge with `creditos`=0: ignored.
- JUGANDO:
  - Outputs: `avance`=1, `credito`=1.
  - Priority is `cancelar` > button edge > timeout.
  - `cancelar`=1: go to REPOSO, `estado`←0, no pulse, credit not refunded.
  - Button edge with `estado`<5: `estado`+1, timeout counter cleared.
  - Button edge with `estado`=5: go to FIN, `fin`=1 for the next cycle.
  - No edge and counter = TIMEOUT_CICLOS−1: go to REPOSO, `estado`←0, `timeout`=1 for one cycle.
  - Otherwise the counter increments.
- FIN:
  - Lasts exactly one cycle. Outputs: `avance`=0, `credito`=1, `estado`=5, `fin`=1.
  - Then unconditionally REPOSO with `estado`←0. Inputs are ignored in FIN except coin counting.
- Credits:
  - Coin edges are counted in every state.
  - next = count + inc − dec.
  - inc while count = MAX_CREDITOS with no dec: held at MAX.
  - Simultaneous inc and dec: count unchanged.
- Counter widths: timeout counter is $clog2(TIMEOUT_CICLOS) bits and never wraps; it is cleared whenever the FSM is not in JUGANDO.
- Reset (any cycle, including mid-game): REPOSO, `estado`=0, `avance`=0, `credito`=0, `creditos`=0, `fin`=0, `timeout`=0, counter=0, both `prev`=1. Credits in flight are lost.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- Input rising edge first sampled at clock edge N: the resulting state and output change is visible right after edge N. Latency 1 cycle from input change.
- `fin` and `timeout` are each high for exactly one cycle, never both high together.
- A new game can start at the earliest 2 cycles after `fin` (FIN cycle, then a REPOSO cycle that samples an edge). The button must go low and high again, since edges are required.
- Back-to-back advance edges every 2 cycles (input toggling each cycle) are all accepted.

## Structure
- Shared package/header `secuenciador_pkg`:
  - State codes REPOSO=2'b00, JUGANDO=2'b01, FIN=2'b10.
  - ETAPA_INICIAL=3'd0, ULTIMA_ETAPA=3'd5.
  - Credit width = 4.
- Sub-module `detector_flanco` (one register + AND, reset value 1), instantiated twice, for `moneda` and `boton_avance`.
- FSM, stage counter, credit counter and timeout counter stay in the top module.
- Expected size ~150–200 lines.

## Test plan
- Reset, then 3 coin pulses → `creditos`=3. Then 14 more → saturates at 15.
- `creditos`=1, button edge → next cycle JUGANDO, `creditos`=0, `estado`=0, `avance`=1, `credito`=1. Five more edges → `estado`=5. Sixth edge → one cycle with `fin`=1, `estado`=5, `avance`=0, then REPOSO with `estado`=0.
- `creditos`=0, button edge → stays REPOSO, all outputs 0.
- TIMEOUT_CICLOS=8, in JUGANDO at `estado`=2, no input → `timeout`=1 for one cycle after the 8th idle cycle, then REPOSO with `estado`=0. Same setup with an edge at idle cycle 7 → no timeout, `estado`=3.
- Button edge and `cancelar` in the same cycle at `estado`=3 → REPOSO, no `fin`/`timeout`. Coin edge and game start in the same cycle at `creditos`=2 → `creditos` stays 2.
- `rst_n`=0 for one cycle mid-game at `estado`=4 with `creditos`=5 → all outputs 0 and `creditos`=0. `boton_avance` held high through reset → no game start.
